picosoc_mem_arbiter: RTL and testbench



---
 rtl/picosoc_pkg.sv | 14 +
 rtl/picosoc_mem_arbiter_if.sv | 12 +
 rtl/picosoc_rr_pick.sv | 28 ++
 rtl/picosoc_mem_arbiter.sv | 108 ++++++++++
 tb/tb_picosoc_mem_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/picosoc_pkg.sv
// Shared types and native-bus field widths for the picosoc SRAM arbiter.
package picosoc_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int MASTER_CNT = 2;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = 4;
  localparam int SRAM_AW    = 22;
endpackage

// File: rtl/picosoc_mem_arbiter_if.sv
// Native valid/ready memory bus: one requester (master) and one responder (slave).
interface picosoc_mem_arbiter_if;
  logic                         valid;
  logic                         ready;
  logic [picosoc_pkg::ADDR_W-1:0] addr;
  logic [picosoc_pkg::DATA_W-1:0] wdata;
  logic [picosoc_pkg::STRB_W-1:0] wstrb;
  logic [picosoc_pkg::DATA_W-1:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/picosoc_rr_pick.sv
// Two-way round-robin picker; remembers which master was granted last.
module picosoc_rr_pick
  import picosoc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MASTER_CNT-1:0] i_req,
  input  logic                  i_adv,
  output logic [MASTER_CNT-1:0] o_pick
);
  logic r_last_m1;

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    o_pick = i_req;
    if (i_req == 2'b11) begin
      o_pick = r_last_m1 ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_m1 <= 1'b1;
    end else if (i_adv) begin
      r_last_m1 <= o_pick[1];
    end
  end
endmodule

// File: rtl/picosoc_mem_arbiter.sv
// Shares one single-port SRAM between two native buses, 3 cycles per access.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed m0 priority.
module picosoc_mem_arbiter
  import picosoc_pkg::*;
#(
  parameter int                WORDS     = 256,
  parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  picosoc_mem_arbiter_if.slave  m0,
  picosoc_mem_arbiter_if.slave  m1,
  output logic [STRB_W-1:0]     sram_wen,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic [MASTER_CNT-1:0] grant
);
  localparam logic [ADDR_W:0] WIN_BYTES = (ADDR_W+1)'(WORDS) << 2;

  arb_state_t              r_state;
  logic [MASTER_CNT-1:0]   r_grant;
  logic [MASTER_CNT-1:0]   r_ready;
  logic                    r_in_range;
  logic [STRB_W-1:0]       r_sram_wen;
  logic [SRAM_AW-1:0]      r_sram_addr;
  logic [DATA_W-1:0]       r_sram_wdata;

  logic [MASTER_CNT-1:0]   w_req;
  logic [MASTER_CNT-1:0]   w_pick;
  logic [ADDR_W-1:0]       w_sel_addr;
  logic [DATA_W-1:0]       w_sel_wdata;
  logic [STRB_W-1:0]       w_sel_wstrb;
  logic [ADDR_W:0]         w_diff;
  logic                    w_in_range;

  assign w_req = {m1.valid, m0.valid};

`ifdef MEM_ARB_RR_EN
  logic w_adv;
  assign w_adv = (r_state == IDLE) && (|w_req);

  picosoc_rr_pick u_rr_pick (
    .clk    (clk),
    .reset  (reset),
    .i_req  (w_req),
    .i_adv  (w_adv),
    .o_pick (w_pick)
  );
`else
  assign w_pick = m0.valid ? 2'b01 : {m1.valid, 1'b0};
`endif

  assign w_sel_addr  = w_pick[1] ? m1.addr  : m0.addr;
  assign w_sel_wdata = w_pick[1] ? m1.wdata : m0.wdata;
  assign w_sel_wstrb = w_pick[1] ? m1.wstrb : m0.wstrb;

  // 33-bit difference: a borrow (addr below base) lands in bit 32 and fails the window check.
  assign w_diff     = {1'b0, w_sel_addr} - {1'b0, ADDR_BASE};
  assign w_in_range = (w_diff < WIN_BYTES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_ready      <= '0;
      r_in_range   <= 1'b0;
      r_sram_wen   <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_grant      <= w_pick;
            r_in_range   <= w_in_range;
            r_sram_addr  <= w_diff[SRAM_AW+1:2];
            r_sram_wdata <= w_sel_wdata;
            r_sram_wen   <= w_in_range ? w_sel_wstrb : '0;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          r_sram_wen <= '0;
          r_ready    <= r_grant;
          r_state    <= RESP;
        end
        RESP: begin
          r_ready <= '0;
          r_grant <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // SRAM output is only meaningful in RESP, so the registered ready pulse gates it.
  assign m0.ready = r_ready[0];
  assign m1.ready = r_ready[1];
  assign m0.rdata = (r_ready[0] && r_in_range) ? sram_rdata : '0;
  assign m1.rdata = (r_ready[1] && r_in_range) ? sram_rdata : '0;

  assign sram_wen   = r_sram_wen;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign grant      = r_grant;
endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// Randomized check of picosoc_mem_arbiter against a transaction-level model.
module tb_picosoc_mem_arbiter;
  import picosoc_pkg::*;

  localparam int          WORDS = 256;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sram_wen;
  logic [21:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  picosoc_mem_arbiter_if m0_if ();
  picosoc_mem_arbiter_if m1_if ();

  picosoc_mem_arbiter #(.WORDS(WORDS), .ADDR_BASE(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0         (m0_if),
    .m1         (m1_if),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .grant      (grant)
  );

  // SRAM fixture: byte-write, registered read, garbage outside the array.
  logic [31:0] sram_mem [WORDS];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (sram_wen[b]) sram_mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    sram_rdata <= (sram_addr < 22'(WORDS)) ? sram_mem[sram_addr[7:0]] : 32'hBAD0_BAD0;
  end

  // Reference model state
  logic [31:0] gold [WORDS];
`ifdef MEM_ARB_RR_EN
  bit last_m1 = 1'b1;
`endif
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] last_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < WORDS);
  endfunction

  task automatic drive(input int m, input bit v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      m0_if.valid = v; m0_if.addr = a; m0_if.wdata = d; m0_if.wstrb = s;
    end else begin
      m1_if.valid = v; m1_if.addr = a; m1_if.wdata = d; m1_if.wstrb = s;
    end
  endtask

  // Entered just after a posedge with the DUT idle; both masters hold valid until served.
  task automatic run_pair(input bit v0, input bit v1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [3:0] s0, input logic [3:0] s1);
    int n; int first;
    int who [2]; logic [31:0] ad [2]; logic [31:0] wd [2]; logic [3:0] sb [2];
    bit inr [2]; bit chk [2]; logic [31:0] erd [2];
    n = 0; first = 0;
    if (v0 && v1) begin
`ifdef MEM_ARB_RR_EN
      first = last_m1 ? 0 : 1;
`endif
      who[0] = first; who[1] = 1 - first; n = 2;
    end else if (v0 || v1) begin
      who[0] = v1 ? 1 : 0; n = 1;
    end
`ifdef MEM_ARB_RR_EN
    if (n > 0) last_m1 = (who[n-1] == 1);
`endif
    for (int s = 0; s < n; s++) begin
      ad[s] = who[s] ? a1 : a0; wd[s] = who[s] ? d1 : d0; sb[s] = who[s] ? s1 : s0;
      inr[s] = in_win(ad[s]);
      if (sb[s] == 4'h0) begin
        chk[s] = 1'b1;
        erd[s] = inr[s] ? gold[(ad[s] - BASE) / 4] : 32'h0;
      end else begin
        chk[s] = !inr[s];
        erd[s] = 32'h0;
        if (inr[s])
          for (int b = 0; b < 4; b++)
            if (sb[s][b]) gold[(ad[s] - BASE) / 4][8*b +: 8] = wd[s][8*b +: 8];
      end
    end
    drive(0, v0, a0, d0, s0);
    drive(1, v1, a1, d1, s1);
    if (n == 0) begin
      @(negedge clk);
      check_eq("idle_grant", 32'(grant), 32'h0);
      check_eq("idle_ready", 32'({m1_if.ready, m0_if.ready}), 32'h0);
      @(posedge clk); #1;
    end
    for (int c = 0; c < 3 * n; c++) begin
      int s; int ph; logic [1:0] oh; logic [31:0] got;
      s = c / 3; ph = c % 3; oh = (who[s] == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      check_eq("grant", 32'(grant), (ph != 0) ? 32'(oh) : 32'h0);
      check_eq("ready", 32'({m1_if.ready, m0_if.ready}), (ph == 2) ? 32'(oh) : 32'h0);
      check_eq("sram_wen", 32'(sram_wen), (ph == 1 && inr[s]) ? 32'(sb[s]) : 32'h0);
      if (ph == 1) begin
        check_eq("sram_addr", 32'(sram_addr), 32'(22'((ad[s] - BASE) >> 2)));
        check_eq("sram_wdata", sram_wdata, wd[s]);
      end
      for (int m = 0; m < 2; m++) begin
        got = m ? m1_if.rdata : m0_if.rdata;
        if (ph == 2 && m == who[s]) begin
          if (chk[s]) begin
            check_eq("rdata", got, erd[s]);
            last_rd = got;
          end
        end else begin
          check_eq("rdata_idle", got, 32'h0);
        end
      end
      @(posedge clk); #1;
      if (ph == 2) drive(who[s], 1'b0, 32'h0, 32'h0, 4'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      sram_mem[i] = 32'h0;
      gold[i]     = 32'h0;
    end
    reset = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_wen", 32'(sram_wen), 32'h0);
    check_eq("rst_addr", 32'(sram_addr), 32'h0);
    check_eq("rst_wdata", sram_wdata, 32'h0);
    check_eq("rst_ready", 32'({m1_if.ready, m0_if.ready}), 32'h0);
    check_eq("rst_rdata", m0_if.rdata | m1_if.rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed: full write, read-back, byte merge
    run_pair(1, 0, 32'h10, 0, 32'hDEADBEEF, 0, 4'hF, 4'h0);
    run_pair(1, 0, 32'h10, 0, 0, 0, 4'h0, 4'h0);
    check_eq("readback", last_rd, 32'hDEADBEEF);
    run_pair(1, 0, 32'h10, 0, 32'h0000AB00, 0, 4'b0010, 4'h0);
    run_pair(1, 0, 32'h10, 0, 0, 0, 4'h0, 4'h0);
    check_eq("byte_merge", last_rd, 32'hDEADABEF);

    // Contention, twice
    run_pair(1, 1, 32'h0, 32'h4, 0, 0, 4'h0, 4'h0);
    run_pair(1, 1, 32'h0, 32'h4, 0, 0, 4'h0, 4'h0);

    // Out-of-window write is dropped, read returns zero
    run_pair(0, 1, 0, 32'h400, 0, 32'h12345678, 4'h0, 4'hF);
    run_pair(0, 1, 0, 32'h400, 0, 0, 4'h0, 4'h0);
    check_eq("oor_read", last_rd, 32'h0);

    // m0 holds valid for four back-to-back reads
    drive(0, 1'b1, 32'h10, 32'h0, 4'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_eq("b2b_ready", 32'(m0_if.ready), (c % 3 == 2) ? 32'h1 : 32'h0);
      if (c % 3 == 0 && c > 0) check_eq("b2b_grant", 32'(grant), 32'h0);
      if (c % 3 == 2) check_eq("b2b_rdata", m0_if.rdata, gold[4]);
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
`ifdef MEM_ARB_RR_EN
    last_m1 = 1'b0;
`endif

    // Reset in ACCESS of an m0 read
    drive(0, 1'b1, 32'h10, 32'h0, 4'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check_eq("mid_rst_grant", 32'(grant), 32'h0);
    check_eq("mid_rst_wen", 32'(sram_wen), 32'h0);
    check_eq("mid_rst_addr", 32'(sram_addr), 32'h0);
    check_eq("mid_rst_wdata", sram_wdata, 32'h0);
    check_eq("mid_rst_ready", 32'({m1_if.ready, m0_if.ready}), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_m1 = 1'b1;
`endif
    @(negedge clk);
    check_eq("post_rst_ready", 32'({m1_if.ready, m0_if.ready}), 32'h0);
    @(posedge clk); #1;
    run_pair(1, 0, 32'h10, 0, 0, 0, 4'h0, 4'h0);

    // Randomized traffic
    for (int it = 0; it < 120; it++) begin
      logic [31:0] a [2]; logic [31:0] d [2]; logic [3:0] s [2]; bit v [2];
      for (int m = 0; m < 2; m++) begin
        v[m] = ($urandom_range(0, 3) != 0);
        a[m] = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 31)) << 2;
        d[m] = $urandom();
        s[m] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      run_pair(v[0], v[1], a[0], a[1], d[0], d[1], s[0], s[1]);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
